// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan decoder and its helpers.
// Segment patterns are low-active: bit0 = top, bits 1..5 clockwise, bit6 = middle.
package seg7_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0011000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic       ok;
    logic       blank;
    logic [3:0] nib;
  } seg7_dec_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex-to-7-segment encoder.
// Optional macro SEG7_SCAN_BLANK_EN: all-segments-off decodes as a blank digit.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output seg7_dec_t  dec
);

  always_comb begin
    dec.ok    = 1'b1;
    dec.blank = 1'b0;
    dec.nib   = 4'h0;
    case (seg_n)
      SEG_HEX_0: dec.nib = 4'h0;
      SEG_HEX_1: dec.nib = 4'h1;
      SEG_HEX_2: dec.nib = 4'h2;
      SEG_HEX_3: dec.nib = 4'h3;
      SEG_HEX_4: dec.nib = 4'h4;
      SEG_HEX_5: dec.nib = 4'h5;
      SEG_HEX_6: dec.nib = 4'h6;
      SEG_HEX_7: dec.nib = 4'h7;
      SEG_HEX_8: dec.nib = 4'h8;
      SEG_HEX_9: dec.nib = 4'h9;
      SEG_HEX_A: dec.nib = 4'hA;
      SEG_HEX_B: dec.nib = 4'hB;
      SEG_HEX_C: dec.nib = 4'hC;
      SEG_HEX_D: dec.nib = 4'hD;
      SEG_HEX_E: dec.nib = 4'hE;
      SEG_HEX_F: dec.nib = 4'hF;
`ifdef SEG7_SCAN_BLANK_EN
      SEG_BLANK: dec.blank = 1'b1;
`endif
      default:   dec.ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reconstructs the hex word shown on a multiplexed low-active 7-segment bus.
// Optional macro SEG7_SCAN_BLANK_EN adds blank-digit decode and the blank_mask port.
//
// state  | meaning
// WAIT   | no digit selected on the synced bus
// SETTLE | a digit is selected, waiting for STABLE_CYCLES identical samples
// HOLD   | current sample already evaluated, waiting for the bus to change
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    frame_valid,
  output logic                    frame_done,
  output logic                    pat_err,
  output logic                    sel_err
`ifdef SEG7_SCAN_BLANK_EN
  ,
  output logic [NUM_DIGITS-1:0]   blank_mask
`endif
);

  localparam logic [7:0] STB = 8'(STABLE_CYCLES);
  localparam int SW = 7 + NUM_DIGITS;

  logic [6:0]              seg_m, s_seg;
  logic [NUM_DIGITS-1:0]   sel_m, s_sel;
  logic [SW-1:0]           prev, sample;
  logic [7:0]              cnt, cnt_nxt;
  logic                    same, idle, onehot, eval;
  logic [3:0]              low_cnt;
  scan_state_t             state, state_nxt;
  seg7_dec_t               dec;

  logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
  logic [NUM_DIGITS-1:0]   mask, mask_nxt;
  logic [NUM_DIGITS-1:0]   sh_blank, sh_blank_nxt;
  logic                    do_cap, do_pat_err, do_sel_err, frame_cmp;

  seg7_to_hex u_dec (
    .seg_n (s_seg),
    .dec   (dec)
  );

  // Select synchronizer idles at all-ones so reset never looks like a selected digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m <= '0;
      s_seg <= '0;
      sel_m <= '1;
      s_sel <= '1;
      prev  <= {7'h00, {NUM_DIGITS{1'b1}}};
      cnt   <= '0;
    end else begin
      seg_m <= seg_n;
      s_seg <= seg_m;
      sel_m <= dig_sel_n;
      s_sel <= sel_m;
      prev  <= sample;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    sample = {s_seg, s_sel};
    same   = (sample == prev);
    idle   = &s_sel;
    if (!same)
      cnt_nxt = 8'd1;
    else if (cnt >= STB)
      cnt_nxt = STB;
    else
      cnt_nxt = cnt + 8'd1;
  end

  always_comb begin
    low_cnt = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!s_sel[i]) low_cnt = low_cnt + 4'd1;
    onehot = (low_cnt == 4'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    eval      = 1'b0;
    case (state)
      WAIT:   if (!idle) state_nxt = SETTLE;
      SETTLE: begin
        if (idle) state_nxt = WAIT;
        else if (cnt_nxt == STB) begin
          eval      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (idle)       state_nxt = WAIT;
        else if (!same) state_nxt = SETTLE;
      end
      default: state_nxt = WAIT;
    endcase
  end

  assign do_sel_err = eval & ~onehot;
  assign do_pat_err = eval & onehot & ~dec.ok;
  assign do_cap     = eval & onehot & dec.ok;

  // Capture is one-hot on the select, so each digit slot is written independently.
  always_comb begin
    shadow_nxt   = shadow;
    sh_blank_nxt = sh_blank;
    mask_nxt     = mask;
    if (do_pat_err) begin
      mask_nxt = '0;
    end else if (do_cap) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!s_sel[i]) begin
          shadow_nxt[4*i +: 4] = dec.nib;
          sh_blank_nxt[i]      = dec.blank;
          mask_nxt[i]          = 1'b1;
        end
      end
    end
    frame_cmp = &mask_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      sh_blank    <= '0;
      mask        <= '0;
      value       <= '0;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
      pat_err     <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      shadow     <= shadow_nxt;
      sh_blank   <= sh_blank_nxt;
      pat_err    <= do_pat_err;
      sel_err    <= do_sel_err;
      frame_done <= frame_cmp;
      if (frame_cmp) begin
        value       <= shadow_nxt;
        frame_valid <= 1'b1;
        mask        <= '0;
      end else begin
        mask <= mask_nxt;
      end
    end
  end

`ifdef SEG7_SCAN_BLANK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         blank_mask <= '0;
    else if (frame_cmp) blank_mask <= sh_blank_nxt;
  end
`else
  logic [NUM_DIGITS-1:0] unused_blank;
  assign unused_blank = sh_blank;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus queues expected events,
// a monitor pops them on frame_done / pat_err / sel_err.
module tb_seg7_scan_decoder;

  localparam int ND = 6;
  localparam int K_FRAME = 0;
  localparam int K_PAT   = 1;
  localparam int K_SEL   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg_n;
  logic [ND-1:0] dig_sel_n;
  logic [23:0]   value;
  logic          frame_valid, frame_done, pat_err, sel_err;
  logic [ND-1:0] blk_obs;

`ifdef SEG7_SCAN_BLANK_EN
  logic [ND-1:0] blank_mask;
  assign blk_obs = blank_mask;
`else
  assign blk_obs = '0;
`endif

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dig_sel_n   (dig_sel_n),
    .value       (value),
    .frame_valid (frame_valid),
    .frame_done  (frame_done),
    .pat_err     (pat_err),
    .sel_err     (sel_err)
`ifdef SEG7_SCAN_BLANK_EN
    ,
    .blank_mask  (blank_mask)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            kind;
    logic [23:0]   val;
    logic [ND-1:0] blk;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  function automatic logic [6:0] hp(input int n);
    case (n)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0011000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic push(input int kind, input logic [23:0] v, input logic [ND-1:0] b);
    ev_t e;
    e.kind = kind;
    e.val  = v;
    e.blk  = b;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Called at a negedge; drives one digit and holds it for n cycles.
  task automatic show(input int d, input logic [6:0] p, input int n);
    logic [ND-1:0] one;
    one       = 1;
    dig_sel_n = ~(one << d);
    seg_n     = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    dig_sel_n = '1;
    seg_n     = '1;
    repeat (n) @(negedge clk);
  endtask

  task automatic handle(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d expected none (value=%0h)", kind, value);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (e.kind == K_FRAME && kind == K_FRAME) begin
        check("frame_value", 32'(value), 32'(e.val));
        check("frame_valid", 32'(frame_valid), 32'd1);
        check("blank_mask", 32'(blk_obs), 32'(e.blk));
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (frame_done) handle(K_FRAME);
        if (pat_err)    handle(K_PAT);
        if (sel_err)    handle(K_SEL);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    rst_n     = 1'b0;
    seg_n     = '1;
    dig_sel_n = '1;
    repeat (3) @(negedge clk);
    check("rst_value", 32'(value), 32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_pat_err", 32'(pat_err), 32'd0);
    check("rst_sel_err", 32'(sel_err), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // Basic scan: digits 0..5 show 1..6
    push(K_FRAME, 24'h654321, 6'b000000);
    for (int d = 0; d < ND; d++) show(d, hp(d + 1), 10);
    idle(5);

    // Latency and glitch rejection on digit0
    push(K_FRAME, 24'h97ECAB, 6'b000000);
    show(1, hp(10), 10);
    show(2, hp(12), 10);
    show(3, hp(14), 10);
    show(4, hp(7), 10);
    show(5, hp(9), 10);
    show(0, 7'b0100100, 3);
    seg_n = 7'b0000011;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) check("latency_early", 32'(frame_done), 32'd0);
      if (k == 6) check("latency_edge", 32'(frame_done), 32'd1);
    end
    repeat (4) @(negedge clk);
    idle(5);

    // Two digits selected at once: sel_err, mask kept
    show(0, hp(0), 10);
    show(1, hp(15), 10);
    show(2, hp(8), 10);
    push(K_SEL, 24'h0, 6'b0);
    dig_sel_n = 6'b111100;
    seg_n     = hp(1);
    repeat (10) @(negedge clk);
    push(K_FRAME, 24'h21D8F0, 6'b000000);
    show(3, hp(13), 10);
    show(4, hp(1), 10);
    show(5, hp(2), 10);
    idle(5);

    // Undecodable pattern mid-frame clears the mask
    show(0, hp(3), 10);
    show(1, hp(4), 10);
    push(K_PAT, 24'h0, 6'b0);
    show(2, 7'b0101010, 10);
    push(K_FRAME, 24'hA98765, 6'b000000);
    for (int d = 0; d < ND; d++) show(d, hp(d + 5), 10);
    idle(5);

    // Reset mid-frame
    show(0, hp(1), 10);
    show(1, hp(2), 10);
    show(2, hp(3), 10);
    dig_sel_n = '1;
    seg_n     = '1;
    rst_n     = 1'b0;
    #1;
    check("midrst_value", 32'(value), 32'd0);
    check("midrst_frame_valid", 32'(frame_valid), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    push(K_FRAME, 24'h0FEDCB, 6'b000000);
    for (int d = 0; d < ND; d++) show(d, hp((d + 11) % 16), 10);
    idle(5);

`ifdef SEG7_SCAN_BLANK_EN
    push(K_FRAME, 24'h650321, 6'b001000);
    show(0, hp(1), 10);
    show(1, hp(2), 10);
    show(2, hp(3), 10);
    show(3, 7'b1111111, 10);
    show(4, hp(5), 10);
    show(5, hp(6), 10);
    idle(5);
`else
    push(K_PAT, 24'h0, 6'b0);
    show(3, 7'b1111111, 10);
    idle(5);
`endif

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL missing_events: got %0d outstanding expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Monitors a multiplexed, low-active 7-segment bus and reconstructs the hex value being displayed. It is the inverse of the team's hex-to-7-segment encoder and is used for display self-test and loopback checks on the HEX outputs. It samples segment lines and active-low digit selects, waits for each digit to be stable, then decodes it to a nibble. It publishes a full multi-digit word once every digit has been captured within one scan frame.

Parameters:
NUM_DIGITS, 6, number of multiplexed digits (valid range 1..8)
STABLE_CYCLES, 4, consecutive identical synced samples required before a capture (valid range 2..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
seg_n  in  7  low-active segment lines; bit0 = top, bits 1..5 clockwise, bit6 = middle
dig_sel_n  in  NUM_DIGITS  low-active digit enables; exactly one low selects a digit
value  out  4*NUM_DIGITS  decoded word; digit i is at value[4i+3:4i]
frame_valid  out  1  high once at least one complete frame has been published
frame_done  out  1  one-cycle pulse when value updates
pat_err  out  1  one-cycle pulse when a stable pattern does not decode
sel_err  out  1  one-cycle pulse when a stable select is not one-hot (more than one low)

Behaviour:
- Reset is asynchronous on rst_n low. Every output goes to 0. Synchronizers, shadow word, capture mask, counter and FSM all clear, and the FSM enters WAIT.
- Input stage: seg_n and dig_sel_n each pass through a 2-flop synchronizer. All logic below uses the synced values s_seg and s_sel.
- Stability counter: cnt increments while {s_seg, s_sel} equals the previous cycle's sample. It reloads to 1 on any change and saturates at STABLE_CYCLES.
- FSM states:
  - WAIT: s_sel is all-ones (no digit selected). Go to SETTLE when any select bit is low.
  - SETTLE: counting toward stability. Go to WAIT if s_sel returns to all-ones. When cnt reaches STABLE_CYCLES, evaluate on that edge:
    - not one-hot: pulse sel_err, go to HOLD with no capture.
    - pattern undecodable: pulse pat_err, clear the capture mask, go to HOLD.
    - otherwise: write the nibble into shadow[digit], set mask[digit], go to HOLD.
  - HOLD: go to SETTLE on any change of s_seg or s_sel while some select is low. Go to WAIT if s_sel becomes all-ones.
- Decode table (seg_n to nibble) is the exact inverse of the encoder:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - Any other pattern is undecodable.
- Frame completion: on the edge where mask becomes all-ones:
  - value is loaded from shadow, including the digit captured on that same edge.
  - frame_done pulses for 1 cycle, frame_valid is set (sticky), and mask clears.
- Re-capturing an already-captured digit before the frame completes overwrites shadow[digit] and leaves mask unchanged.
- Latency: an input held stable from cycle t updates shadow/value on the edge at t + 2 + STABLE_CYCLES.
- A glitch shorter than STABLE_CYCLES synced cycles produces no capture and no error pulse.
- Simultaneous pat_err and frame completion cannot occur: an error blocks the capture.
- rst_n asserted mid-frame discards the partial frame. value returns to 0 immediately.

Optional Feature:
SEG7_SCAN_BLANK_EN
- Defined: pattern 1111111 (all segments off) decodes as "blank". The digit is captured with nibble 0 and a per-digit flag is set. An extra output blank_mask [NUM_DIGITS] is loaded alongside value at frame completion and reset to 0. No pat_err is raised for blank.
- Not defined: 1111111 is undecodable and pulses pat_err. The blank_mask port does not exist.

Decomposition:
- Package seg7_pkg:
  - 7-bit localparams SEG_HEX_0..SEG_HEX_F and SEG_BLANK.
  - FSM state enum typedef (WAIT, SETTLE, HOLD).
  - A seg7_dec_t struct {logic ok; logic blank; logic [3:0] nib}.
- Sub-module seg7_to_hex: purely combinational, seg_n[6:0] in, seg7_dec_t out. Shared with future loopback checkers.

Test Plan:
- NUM_DIGITS=6, STABLE_CYCLES=4. Scan digits 0..5 with patterns for 1,2,3,4,5,6, each held 10 cycles, using active-low one-hot selects -> frame_done pulses once, value=24'h654321, frame_valid=1.
- Hold digit0 at pattern 0000011 from cycle 0 -> shadow[0]=4'hB updated on the edge at cycle 6. An earlier 3-cycle glitch to 0100100 causes no capture and no error.
- dig_sel_n=6'b111100 held 10 cycles -> sel_err pulses exactly once, mask and value unchanged.
- Stable pattern 0101010 on digit2 mid-frame -> pat_err pulses once, mask clears. The next full scan of 6 digits still produces frame_done with the correct value.
- Assert rst_n low for 1 cycle after 3 of 6 digits are captured -> all outputs 0 immediately. After a full rescan, frame_done pulses with only the new digits in value.
- With SEG7_SCAN_BLANK_EN: digit3 pattern 1111111 in a full scan -> no pat_err, blank_mask=6'b001000, value[15:12]=0.
